clip_window: RTL and testbench
==============================

CLIP_WINDOW -- requirements
Module: clip_window

Interface
REQ-001 Parameter CHANNELS, default 1, SHALL set the number of pixel channels carried per beat.
REQ-002 Parameter IMG_WIDTH, default 8, SHALL set the bits per channel.
REQ-003 Parameter DIM_WIDTH, default 12, SHALL set the bits of every dimension and crop field.
REQ-004 Port clk, input, 1, SHALL be the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-006 Port cfg_width, input, DIM_WIDTH, SHALL give pixels per input row.
REQ-007 Port cfg_height, input, DIM_WIDTH, SHALL give rows per input frame.
REQ-008 Ports cfg_left, cfg_right, cfg_top, cfg_bottom, input, DIM_WIDTH each, SHALL give pixels/rows removed at each edge.
REQ-009 Port cfg_set, input, 1, SHALL load all cfg_* fields when high.
REQ-010 Port up_data, input, CHANNELS*IMG_WIDTH, SHALL carry the upstream pixel, channel 0 in the LSBs.
REQ-011 Port up_val, input, 1, SHALL mark up_data valid.
REQ-012 Port up_rdy, output, 1, SHALL indicate the block accepts a beat this cycle.
REQ-013 Port dn_data, output, CHANNELS*IMG_WIDTH, SHALL carry the retained pixel.
REQ-014 Port dn_val, output, 1, SHALL mark dn_data valid.
REQ-015 Port dn_rdy, input, 1, SHALL indicate downstream accepts dn_data.

Function
REQ-016 An up beat SHALL transfer when up_val and up_rdy are both high; a dn beat SHALL transfer when dn_val and dn_rdy are both high.
REQ-017 up_rdy SHALL equal (dn_rdy or not dn_val) and not cfg_set, combinationally.
REQ-018 The block SHALL keep a column counter col and a row counter row, both 0 after reset or cfg_set.
REQ-019 On every up transfer, col SHALL increment; at col = width-1 it SHALL wrap to 0 and row SHALL increment; at row = height-1 with that wrap, row SHALL also wrap to 0 (frame end).
REQ-020 A transferred pixel SHALL be retained iff left <= col <= width-1-right and top <= row <= height-1-bottom, evaluated in DIM_WIDTH+1-bit arithmetic so that no underflow occurs.
REQ-021 Retained pixels SHALL appear on dn_data with dn_val high exactly one cycle after transfer (one output register); cropped pixels SHALL be consumed without asserting dn_val.
REQ-022 dn_data and dn_val SHALL hold stable while dn_val is high and dn_rdy is low.
REQ-023 If a dn transfer and an up transfer of a retained pixel occur in the same cycle, the register SHALL load the new pixel and dn_val SHALL stay high (full throughput, no bubble).
REQ-024 When left+right >= width or top+bottom >= height, no pixel SHALL be retained; counters SHALL still advance.
REQ-025 When the loaded width or height is 0, all beats SHALL be accepted and discarded, and counters SHALL hold at 0.
REQ-026 cfg_set SHALL take effect at the next edge: it loads the config, zeroes col/row, and leaves any pending dn beat intact.
REQ-027 Channels SHALL pass unmodified and in order; the block SHALL perform no arithmetic on pixel data.

Reset
REQ-028 On rst high at a rising edge, dn_val, dn_data, col, row and all loaded config fields SHALL become 0, so the block discards all input until configured.
REQ-029 rst mid-frame SHALL drop any pending dn beat; rst SHALL take priority over cfg_set.

Structure
REQ-030 The shared package clip_pkg SHALL hold the default CHANNELS, IMG_WIDTH and DIM_WIDTH constants and the config-field bundle typedef.
REQ-031 The col/row counting and wrap logic SHALL be a sub-module, raster_cnt, instantiated once.

Verification
REQ-032 Crop test: width=6, height=4, left=1, right=2, top=1, bottom=1, and 24 beats of data 1..24 with dn_rdy=1 -> dn carries exactly 8,9,10,14,15,16, each one cycle after its input.
REQ-033 Backpressure test: same config, with dn_rdy toggling 1010... -> identical output sequence, no loss or duplication, dn_data stable while stalled.
REQ-034 Frame wrap test: the same config over 48 consecutive beats -> the output of the second frame matches the first, offset by 24.
REQ-035 Degenerate test: width=4, left=2, right=2 -> up_rdy stays high and dn_val never asserts; width=0 -> same.
REQ-036 Reconfigure/reset test: cfg_set asserted after beat 10 -> up_rdy is low that cycle and beat 11 is treated as col=0, row=0; rst asserted with dn_val high -> dn_val=0 at the next edge.
REQ-037 Multi-channel test: CHANNELS=3, IMG_WIDTH=8, passthrough config (all crops 0, 4x2) -> 8 outputs bit-identical to the 24-bit inputs.

Source files
------------

// File: rtl/clip_pkg.sv
//------------------------------------------------------------------------------
// Module : clip_pkg
// Brief  : Shared defaults, crop-config bundle and span test for clip_window.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package clip_pkg;

  localparam int unsigned c_channels  = 1;
  localparam int unsigned c_img_width = 8;
  localparam int unsigned c_dim_width = 12;

  typedef logic [c_dim_width-1:0] dim_t;

  typedef struct packed {
    dim_t width;
    dim_t height;
    dim_t left;
    dim_t right;
    dim_t top;
    dim_t bottom;
  } cfg_t;

  // lo <= pos <= extent-1-hi_crop, rewritten as pos+hi_crop < extent so nothing underflows
  function automatic logic in_span(input dim_t pos, input dim_t lo,
                                   input dim_t hi_crop, input dim_t extent);
    logic [c_dim_width:0] w_end;
    w_end = {1'b0, pos} + {1'b0, hi_crop};
    return (pos >= lo) && (w_end < {1'b0, extent});
  endfunction

endpackage

`default_nettype wire

// File: rtl/raster_cnt.sv
//------------------------------------------------------------------------------
// Module : raster_cnt
// Brief  : Column/row raster position counter with frame wrap.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module raster_cnt #(
  parameter int DIM_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [DIM_WIDTH-1:0] width,
  input  logic [DIM_WIDTH-1:0] height,
  output logic [DIM_WIDTH-1:0] col,
  output logic [DIM_WIDTH-1:0] row
);

  localparam logic [DIM_WIDTH-1:0] c_one = DIM_WIDTH'(1);

  logic [DIM_WIDTH-1:0] r_col;
  logic [DIM_WIDTH-1:0] r_row;
  logic                 w_empty;
  logic                 w_col_end;
  logic                 w_row_end;

  // A zero-sized frame makes width-1 meaningless, so counting is frozen instead
  assign w_empty   = (width == '0) || (height == '0);
  assign w_col_end = (r_col == width - c_one);
  assign w_row_end = (r_row == height - c_one);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (adv && !w_empty) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + c_one;
      end else begin
        r_col <= r_col + c_one;
      end
    end
  end

  assign col = r_col;
  assign row = r_row;

endmodule

`default_nettype wire

// File: rtl/clip_window.sv
//------------------------------------------------------------------------------
// Module : clip_window
// Brief  : Streaming crop window; keeps pixels inside the configured margins.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module clip_window
  import clip_pkg::*;
#(
  parameter int CHANNELS  = c_channels,
  parameter int IMG_WIDTH = c_img_width,
  parameter int DIM_WIDTH = c_dim_width
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIM_WIDTH-1:0]          cfg_width,
  input  logic [DIM_WIDTH-1:0]          cfg_height,
  input  logic [DIM_WIDTH-1:0]          cfg_left,
  input  logic [DIM_WIDTH-1:0]          cfg_right,
  input  logic [DIM_WIDTH-1:0]          cfg_top,
  input  logic [DIM_WIDTH-1:0]          cfg_bottom,
  input  logic                          cfg_set,
  input  logic [CHANNELS*IMG_WIDTH-1:0] up_data,
  input  logic                          up_val,
  output logic                          up_rdy,
  output logic [CHANNELS*IMG_WIDTH-1:0] dn_data,
  output logic                          dn_val,
  input  logic                          dn_rdy
);

  localparam int c_data_w = CHANNELS * IMG_WIDTH;

  cfg_t                r_cfg;
  logic [c_data_w-1:0] r_dn_data;
  logic                r_dn_val;
  dim_t                w_col;
  dim_t                w_row;
  logic                w_up_xfer;
  logic                w_keep;

  // Accept whenever the output slot is free or draining, except while reconfiguring
  assign up_rdy    = (dn_rdy || !r_dn_val) && !cfg_set;
  assign w_up_xfer = up_val && up_rdy;
  assign w_keep    = in_span(w_col, r_cfg.left, r_cfg.right,  r_cfg.width) &&
                     in_span(w_row, r_cfg.top,  r_cfg.bottom, r_cfg.height);

  // Fields are held at package width; narrower ports zero-extend into them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg <= '0;
    end else if (cfg_set) begin
      r_cfg.width  <= dim_t'(cfg_width);
      r_cfg.height <= dim_t'(cfg_height);
      r_cfg.left   <= dim_t'(cfg_left);
      r_cfg.right  <= dim_t'(cfg_right);
      r_cfg.top    <= dim_t'(cfg_top);
      r_cfg.bottom <= dim_t'(cfg_bottom);
    end
  end

  raster_cnt #(
    .DIM_WIDTH (c_dim_width)
  ) u_raster_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cfg_set),
    .adv    (w_up_xfer),
    .width  (r_cfg.width),
    .height (r_cfg.height),
    .col    (w_col),
    .row    (w_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dn_val  <= 1'b0;
      r_dn_data <= '0;
    end else if (w_up_xfer && w_keep) begin
      r_dn_val  <= 1'b1;
      r_dn_data <= up_data;
    end else if (dn_rdy) begin
      r_dn_val  <= 1'b0;
    end
  end

  assign dn_data = r_dn_data;
  assign dn_val  = r_dn_val;

endmodule

`default_nettype wire

// File: tb/tb_clip_window.sv
//------------------------------------------------------------------------------
// Module : tb_clip_window
// Brief  : Self-checking bench for clip_window (vector table + random model).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clip_window;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_width, cfg_height, cfg_left, cfg_right, cfg_top, cfg_bottom;
  logic        cfg_set;
  logic [7:0]  up_data;
  logic        up_val;
  logic        up_rdy;
  logic [7:0]  dn_data;
  logic        dn_val;
  logic        dn_rdy;
  logic [23:0] up_data3;
  logic        up_rdy3;
  logic [23:0] dn_data3;
  logic        dn_val3;

  always #5 clk = ~clk;

  clip_window dut (
    .clk(clk), .rst(rst),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_left(cfg_left),
    .cfg_right(cfg_right), .cfg_top(cfg_top), .cfg_bottom(cfg_bottom),
    .cfg_set(cfg_set), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy)
  );

  clip_window #(.CHANNELS(3), .IMG_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_left(cfg_left),
    .cfg_right(cfg_right), .cfg_top(cfg_top), .cfg_bottom(cfg_bottom),
    .cfg_set(cfg_set), .up_data(up_data3), .up_val(up_val), .up_rdy(up_rdy3),
    .dn_data(dn_data3), .dn_val(dn_val3), .dn_rdy(dn_rdy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: position of the k-th accepted beat since the last config
  int m_w, m_h, m_l, m_r, m_t, m_b, m_k;

  function automatic bit m_keep(input int k);
    int c, r;
    if (m_w == 0 || m_h == 0) return 1'b0;
    c = k % m_w;
    r = (k / m_w) % m_h;
    return (c >= m_l) && (c <= m_w - 1 - m_r) && (r >= m_t) && (r <= m_h - 1 - m_b);
  endfunction

  task automatic configure(input int w, input int h, input int l, input int r,
                           input int t, input int b);
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_left = 12'(l);
    cfg_right = 12'(r); cfg_top = 12'(t); cfg_bottom = 12'(b);
    up_val = 1'b0; cfg_set = 1'b1;
    @(posedge clk); #1;
    cfg_set = 1'b0;
    m_w = w; m_h = h; m_l = l; m_r = r; m_t = t; m_b = b; m_k = 0;
  endtask

  logic [7:0] got_q[$];

  // mode 0: dn_rdy=1, 1: dn_rdy toggles 1010..., 2: random valid/ready/data
  task automatic run_stream(input int n, input int mode, input int base);
    logic [7:0] q[$];
    int sent = 0, cyc = 0, budget;
    bit xfer, keep, stall = 1'b0;
    logic [7:0] px, stall_px = '0;
    budget = n * 8 + 40;
    got_q.delete();
    while ((sent < n || q.size() > 0) && cyc < budget) begin
      dn_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (sent < n) begin
        up_val  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        up_data = (mode == 2) ? 8'($urandom) : 8'(base + sent + 1);
      end else begin
        up_val = 1'b0;
      end
      #1;
      check("up_rdy_rule", up_rdy, (dn_rdy || !dn_val) && !cfg_set);
      xfer = up_val && up_rdy;
      keep = xfer && m_keep(m_k);
      px   = up_data;
      if (dn_val && dn_rdy) begin
        if (q.size() == 0) begin
          check("dn_extra_beat", dn_data, 64'hFFFF_FFFF);
        end else begin
          check("dn_sequence", dn_data, q.pop_front());
          got_q.push_back(dn_data);
        end
      end
      stall = dn_val && !dn_rdy;
      stall_px = dn_data;
      @(posedge clk); #1;
      if (xfer) begin m_k++; sent++; end
      if (keep) begin
        q.push_back(px);
        check("latency_val", dn_val, 1'b1);
        check("latency_data", dn_data, px);
      end else if (stall) begin
        check("stall_val", dn_val, 1'b1);
        check("stall_data", dn_data, stall_px);
      end else begin
        check("no_spurious_val", dn_val, 1'b0);
      end
      cyc++;
    end
    up_val = 1'b0; dn_rdy = 1'b1;
    if (cyc >= budget) check("stream_timeout", cyc, budget - 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       exp_val;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[24];

  initial begin
    for (int i = 0; i < 24; i++) begin
      tbl[i].data     = 8'(i + 1);
      tbl[i].exp_val  = (i + 1) inside {8, 9, 10, 14, 15, 16};
      tbl[i].exp_data = 8'(i + 1);
    end

    rst = 1'b1; cfg_set = 1'b0; up_val = 1'b0; up_data = '0; up_data3 = '0; dn_rdy = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_left = '0; cfg_right = '0; cfg_top = '0; cfg_bottom = '0;
    m_w = 0; m_h = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_k = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dn_val", dn_val, 1'b0);
    check("reset_dn_data", dn_data, 8'h00);
    check("reset_up_rdy", up_rdy, 1'b1);
    rst = 1'b0;

    // Unconfigured block swallows everything
    run_stream(6, 0, 100);
    check("unconfigured_outputs", got_q.size(), 0);

    // Crop vectors, one cycle latency
    configure(6, 4, 1, 2, 1, 1);
    dn_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      up_val = 1'b1; up_data = tbl[i].data;
      @(posedge clk); #1;
      check($sformatf("crop_val[%0d]", i + 1), dn_val, tbl[i].exp_val);
      if (tbl[i].exp_val) check($sformatf("crop_data[%0d]", i + 1), dn_data, tbl[i].exp_data);
    end
    up_val = 1'b0;
    @(posedge clk); #1;

    // Backpressure
    configure(6, 4, 1, 2, 1, 1);
    run_stream(24, 1, 0);
    check("bp_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      logic [7:0] exp_bp[6] = '{8, 9, 10, 14, 15, 16};
      for (int i = 0; i < 6; i++) check($sformatf("bp_seq[%0d]", i), got_q[i], exp_bp[i]);
    end

    // Frame wrap
    configure(6, 4, 1, 2, 1, 1);
    run_stream(48, 0, 0);
    check("wrap_count", got_q.size(), 12);
    if (got_q.size() == 12)
      for (int i = 0; i < 6; i++) check($sformatf("wrap[%0d]", i), got_q[i + 6], got_q[i] + 8'd24);

    // Degenerate windows
    configure(4, 4, 2, 2, 0, 0);
    run_stream(16, 0, 0);
    check("degen_lr_count", got_q.size(), 0);
    configure(0, 4, 0, 0, 0, 0);
    run_stream(16, 0, 0);
    check("degen_w0_count", got_q.size(), 0);
    configure(4, 3, 0, 0, 2, 1);
    run_stream(12, 0, 0);
    check("degen_tb_count", got_q.size(), 0);

    // Reconfigure after beat 10 with a pending output
    configure(6, 4, 1, 2, 1, 1);
    for (int i = 1; i <= 10; i++) begin
      up_val = 1'b1; up_data = 8'(i); dn_rdy = 1'b1;
      @(posedge clk); #1;
    end
    check("reconf_pending_val", dn_val, 1'b1);
    check("reconf_pending_data", dn_data, 8'd10);
    dn_rdy = 1'b0; cfg_set = 1'b1; up_data = 8'd11;
    #1;
    check("reconf_up_rdy_low", up_rdy, 1'b0);
    @(posedge clk); #1;
    cfg_set = 1'b0; up_val = 1'b0;
    check("reconf_kept_val", dn_val, 1'b1);
    check("reconf_kept_data", dn_data, 8'd10);
    dn_rdy = 1'b1;
    @(posedge clk); #1;
    check("reconf_drained", dn_val, 1'b0);
    m_k = 0;
    run_stream(24, 0, 10);
    check("reconf_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      logic [7:0] exp_rc[6] = '{18, 19, 20, 24, 25, 26};
      for (int i = 0; i < 6; i++) check($sformatf("reconf_seq[%0d]", i), got_q[i], exp_rc[i]);
    end

    // Reset with a pending beat, reset beats cfg_set
    configure(6, 4, 1, 2, 1, 1);
    for (int i = 1; i <= 8; i++) begin
      up_val = 1'b1; up_data = 8'(i); dn_rdy = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_pre_val", dn_val, 1'b1);
    up_val = 1'b0; dn_rdy = 1'b0; rst = 1'b1; cfg_set = 1'b1;
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_left = '0; cfg_right = '0; cfg_top = '0; cfg_bottom = '0;
    @(posedge clk); #1;
    rst = 1'b0; cfg_set = 1'b0;
    check("rst_dn_val", dn_val, 1'b0);
    check("rst_dn_data", dn_data, 8'h00);
    m_w = 0; m_h = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_k = 0;
    run_stream(8, 0, 50);
    check("rst_cfg_cleared", got_q.size(), 0);

    // Random configurations against the model
    for (int it = 0; it < 8; it++) begin
      configure($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      run_stream(40, 2, 0);
    end

    // Multi-channel passthrough
    configure(4, 2, 0, 0, 0, 0);
    dn_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [23:0] px3;
      px3 = 24'($urandom);
      up_val = 1'b1; up_data3 = px3;
      @(posedge clk); #1;
      check($sformatf("mc_val[%0d]", i), dn_val3, 1'b1);
      check($sformatf("mc_data[%0d]", i), dn_data3, px3);
    end
    up_val = 1'b0;
    @(posedge clk); #1;
    check("mc_idle", dn_val3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
